uriscv_axi_sram: RTL and testbench
==================================

// Module: uriscv_axi_sram
// PURPOSE
//  AXI4 slave that terminates the uriscv core AXI master port on a single-port synchronous SRAM (BRAM).
//  Serves single-beat and INCR/FIXED bursts, one transaction at a time, with round-robin between writes and reads.
//  Sits directly downstream of the core AXI master and is the boot/data memory at 0x2000_0000.
// PARAMETERS
//  MEM_AW      14   SRAM word-address width (2^MEM_AW x 32-bit words, default 64 KiB)
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst       in   1       asynchronous, active-high reset
//  awaddr    in   32      write address; bits [MEM_AW+1:2] used, others ignored (aliasing)
//  awlen     in   8       write burst length - 1
//  awsize    in   3       accepted, unused (byte lanes taken from wstrb)
//  awburst   in   2       00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
//  awvalid   in   1       / awready  out 1
//  wdata     in   32      / wstrb in 4 / wlast in 1 / wvalid in 1 / wready out 1
//  bresp     out  2       / bvalid out 1 / bready in 1
//  araddr    in   32      / arlen in 8 / arsize in 3 (unused) / arburst in 2 / arvalid in 1 / arready out 1
//  rdata     out  32      / rresp out 2 / rlast out 1 / rvalid out 1 / rready in 1
//  mem_cs    out  1       SRAM access enable
//  mem_we    out  4       SRAM byte write enables (0 = read)
//  mem_addr  out  MEM_AW  SRAM word address
//  mem_wdata out  32      SRAM write data
//  mem_rdata in   32      SRAM read data; valid the cycle after a read mem_cs and held until the next read
// BEHAVIOUR
//  Reset: state IDLE; awready=wready=arready=0, bvalid=rvalid=rlast=0, bresp=rresp=2'b00, mem_cs=0, mem_we=0,
//   addr/count cleared, last_grant=READ. Reset mid-transaction abandons it; no response is issued.
//  FSM: IDLE, WDATA, WRESP, RADDR, RDATA.
//  IDLE: awready = awvalid & grant_w; arready = arvalid & ~grant_w (combinational, IDLE only).
//   Both valid: grant the side not in last_grant; one valid: grant it. On handshake: capture addr[MEM_AW+1:2],
//   len, burst; clear beat count and err flag; update last_grant; go to WDATA or RADDR.
//  WDATA: wready=1. Each wvalid beat: mem_cs=1, mem_we=wstrb, mem_wdata=wdata, mem_addr=cur addr (same cycle).
//   err |= (wlast != (count==len)). After beat: addr += 1 if INCR/WRAP, held if FIXED; count += 1.
//   Beat with count==len or wlast=1 -> WRESP (early wlast ends burst; err set).
//  WRESP: bvalid=1, bresp = err ? 2'b10 (SLVERR) : 2'b00; hold until bready; then IDLE.
//  RADDR: one cycle, mem_cs=1, mem_we=0 -> RDATA.
//  RDATA: rvalid=1, rdata=mem_rdata, rresp=00, rlast=(count==len); held stable until rready.
//   On rready: last -> IDLE; else addr step (as write), count += 1 -> RADDR.
//  Latency: aw handshake cycle N -> wready N+1 -> bvalid N+2 (single beat, wvalid already high).
//   ar handshake cycle N -> mem_cs N+1 -> rvalid N+2; burst read throughput 1 beat / 2 cycles.
//  Address wraps modulo 2^MEM_AW on increment. awlen/arlen=255 -> 256 beats; count is 8 bits.
//  wvalid before awvalid: W beats wait (wready=0 outside WDATA). Never both mem read and write in a cycle.
// STRUCTURE
//  Package uriscv_axi_pkg: burst codes (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), state enum axi_sram_state_t.
//  Sub-module uriscv_axi_burst_addr: shared next-address/beat-count/last logic, instantiated once (one txn at a time).
// TESTING
//  Single write: aw 0x2000_0010 len0, w 0xDEADBEEF strb F -> mem_we=F, mem_addr=4 at N+1; bvalid/OKAY at N+2.
//  Byte write: strb 4'b0100 data 0x00AB0000 to 0x2000_0010, then read -> rdata 0xDEAB BEEF pattern 0xDEABBEEF.
//  INCR read arlen=3 from 0x2000_0000, rready toggling 1/0 -> 4 beats addr 0..3, rdata stable while stalled, rlast on 4th only.
//  awvalid & arvalid same cycle after reset -> write granted first, read next; repeat -> read first.
//  Write awlen=3 with wlast on beat 2 -> 2 SRAM writes, bresp=2'b10; next txn OKAY.
//  rst pulse during RDATA of a burst -> rvalid=0 next cycle, state IDLE, later read completes normally.

Source files
------------

// File: rtl/uriscv_axi_pkg.sv
// Shared AXI burst/response codes and FSM state encoding for the uriscv AXI SRAM slave.
package uriscv_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } axi_sram_state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/uriscv_axi_sram_if.sv
// AXI4 channel bundle between the uriscv core master and the SRAM slave.
interface uriscv_axi_sram_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/uriscv_axi_burst_addr.sv
// Word address and beat counter for the single in-flight burst, shared by reads and writes.
module uriscv_axi_burst_addr
  import uriscv_axi_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [1:0]        i_burst,
  input  logic              i_step,
  output logic [MEM_AW-1:0] o_addr,
  output logic              o_last
);

  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_count;
  logic [7:0]        r_len;
  logic [1:0]        r_burst;
  logic [MEM_AW-1:0] w_addr_next;

  // FIXED holds the address; INCR and WRAP both step and wrap modulo the SRAM size
  always_comb begin
    if (r_burst == BURST_FIXED) begin
      w_addr_next = r_addr;
    end else begin
      w_addr_next = r_addr + ADDR_ONE;
    end
  end

  // burst context register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= {MEM_AW{1'b0}};
      r_count <= 8'd0;
      r_len   <= 8'd0;
      r_burst <= BURST_INCR;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_count <= 8'd0;
      r_len   <= i_len;
      r_burst <= i_burst;
    end else if (i_step) begin
      r_addr  <= w_addr_next;
      r_count <= r_count + 8'd1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_count == r_len);

endmodule

// File: rtl/uriscv_axi_sram.sv
// AXI4 slave terminating the uriscv core master on a single-port synchronous SRAM;
// one transaction at a time, reads and writes arbitrated round-robin.
module uriscv_axi_sram
  import uriscv_axi_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uriscv_axi_sram_if.slave   s_axi,
  output logic               o_mem_cs,
  output logic [3:0]         o_mem_we,
  output logic [MEM_AW-1:0]  o_mem_addr,
  output logic [31:0]        o_mem_wdata,
  input  logic [31:0]        i_mem_rdata
);

  axi_sram_state_t   r_state;
  axi_sram_state_t   w_state_next;
  grant_t            r_last_grant;
  logic              r_err;
  logic              w_grant_w;
  logic              w_aw_hs;
  logic              w_ar_hs;
  logic              w_wbeat;
  logic              w_rdone;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [MEM_AW-1:0] w_addr;
  logic [MEM_AW-1:0] w_load_addr;
  logic [7:0]        w_load_len;
  logic [1:0]        w_load_burst;
  logic              w_unused;

  // On contention the side that did not win last time gets the slot
  assign w_grant_w = s_axi.awvalid & (~s_axi.arvalid | (r_last_grant == GRANT_READ));
  assign w_aw_hs   = (r_state == ST_IDLE) & s_axi.awvalid & w_grant_w;
  assign w_ar_hs   = (r_state == ST_IDLE) & s_axi.arvalid & ~w_grant_w;
  assign w_wbeat   = (r_state == ST_WDATA) & s_axi.wvalid;
  assign w_rdone   = (r_state == ST_RDATA) & s_axi.rready;
  assign w_load    = w_aw_hs | w_ar_hs;
  assign w_step    = w_wbeat | (w_rdone & ~w_last);

  assign w_load_addr  = w_aw_hs ? s_axi.awaddr[MEM_AW+1:2] : s_axi.araddr[MEM_AW+1:2];
  assign w_load_len   = w_aw_hs ? s_axi.awlen : s_axi.arlen;
  assign w_load_burst = w_aw_hs ? s_axi.awburst : s_axi.arburst;

  assign w_unused = ^{s_axi.awsize, s_axi.arsize,
                      s_axi.awaddr[31:MEM_AW+2], s_axi.awaddr[1:0],
                      s_axi.araddr[31:MEM_AW+2], s_axi.araddr[1:0]};

  uriscv_axi_burst_addr #(.MEM_AW(MEM_AW)) u_burst_addr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_addr  (w_load_addr),
    .i_len   (w_load_len),
    .i_burst (w_load_burst),
    .i_step  (w_step),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // state, arbitration history and write-burst error flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_READ;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_aw_hs) begin
        r_last_grant <= GRANT_WRITE;
        r_err        <= 1'b0;
      end else if (w_ar_hs) begin
        r_last_grant <= GRANT_READ;
        r_err        <= 1'b0;
      end else if (w_wbeat) begin
        r_err <= r_err | (s_axi.wlast ^ w_last);
      end
    end
  end

  // next state, AXI handshake outputs and SRAM strobes
  always_comb begin
    w_state_next  = r_state;
    s_axi.awready = w_aw_hs;
    s_axi.arready = w_ar_hs;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.bresp   = RESP_OKAY;
    s_axi.rvalid  = 1'b0;
    s_axi.rdata   = 32'h0000_0000;
    s_axi.rresp   = RESP_OKAY;
    s_axi.rlast   = 1'b0;
    o_mem_cs      = 1'b0;
    o_mem_we      = 4'h0;
    o_mem_addr    = w_addr;
    o_mem_wdata   = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        if (w_aw_hs) begin
          w_state_next = ST_WDATA;
        end else if (w_ar_hs) begin
          w_state_next = ST_RADDR;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WDATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid) begin
          o_mem_cs    = 1'b1;
          o_mem_we    = s_axi.wstrb;
          o_mem_wdata = s_axi.wdata;
          // an early wlast terminates the burst; the error flag records it
          if (w_last | s_axi.wlast) begin
            w_state_next = ST_WRESP;
          end else begin
            w_state_next = ST_WDATA;
          end
        end else begin
          w_state_next = ST_WDATA;
        end
      end
      ST_WRESP: begin
        s_axi.bvalid = 1'b1;
        s_axi.bresp  = resp_of(r_err);
        if (s_axi.bready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WRESP;
        end
      end
      ST_RADDR: begin
        o_mem_cs     = 1'b1;
        w_state_next = ST_RDATA;
      end
      ST_RDATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rdata  = i_mem_rdata;
        s_axi.rlast  = w_last;
        if (s_axi.rready) begin
          if (w_last) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RADDR;
          end
        end else begin
          w_state_next = ST_RDATA;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uriscv_axi_sram.sv
// Directed, table-driven bench for uriscv_axi_sram with a behavioural single-port SRAM.
module tb_uriscv_axi_sram;
  import uriscv_axi_pkg::*;

  localparam int MEM_AW = 14;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uriscv_axi_sram_if bus();

  logic              mem_cs;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  logic [31:0] rd_buf [0:255];
  int rd_last_err, rd_unstable, rd_stalls, rd_resp_err;

  uriscv_axi_sram #(.MEM_AW(MEM_AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_axi       (bus),
    .o_mem_cs    (mem_cs),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // SRAM model: byte-enable write, registered read
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  always @(posedge clk) if (mem_cs && mem_we != 4'h0) n_wr <= n_wr + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.awaddr = 32'h0; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = 32'h0; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  // called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic wait_ready(input int ch, output bit ok, output logic [1:0] resp);
    bit r;
    ok = 1'b0;
    resp = 2'b00;
    for (int i = 0; i < 64; i++) begin
      #1;
      case (ch)
        0: r = bus.awready;
        1: r = bus.wready;
        2: r = bus.bvalid;
        3: r = bus.arready;
        default: r = 1'b0;
      endcase
      if (ch == 2) resp = bus.bresp;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout ch%0d: got no ready, expected ready within 64 cycles", ch);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] base, input logic [3:0] strb, input int wlast_at,
                          output logic [1:0] resp);
    bit ok;
    logic [1:0] s;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    wait_ready(0, ok, s);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = base + 32'(i); bus.wstrb = strb; bus.wlast = (i == wlast_at); bus.wvalid = 1'b1;
      wait_ready(1, ok, s);
      if (!ok || i == wlast_at) break;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    wait_ready(2, ok, s);
    resp = s;
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit stall);
    bit ok, have_prev;
    logic [1:0] s;
    logic [31:0] prev;
    int beat, cyc;
    rd_last_err = 0; rd_unstable = 0; rd_stalls = 0; rd_resp_err = 0;
    bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    wait_ready(3, ok, s);
    bus.arvalid = 1'b0;
    beat = 0; cyc = 0; have_prev = 1'b0; prev = 32'h0;
    while (beat <= int'(len) && cyc < 3000) begin
      bus.rready = stall ? (cyc % 3 == 2) : 1'b1;
      #1;
      if (bus.rvalid) begin
        if (have_prev && bus.rdata !== prev) rd_unstable++;
        if (bus.rready) begin
          rd_buf[beat] = bus.rdata;
          if (bus.rlast !== (beat == int'(len))) rd_last_err++;
          if (bus.rresp !== 2'b00) rd_resp_err++;
          beat++;
          have_prev = 1'b0;
        end else begin
          prev = bus.rdata;
          have_prev = 1'b1;
          rd_stalls++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    if (beat <= int'(len)) begin
      n_tests++; n_fail++;
      $display("FAIL read_timeout: got %0d beats, expected %0d", beat, int'(len) + 1);
    end
  endtask

  // drives both AW/W and AR together; records the cycle each address handshake happened
  task automatic arb(input logic [31:0] waddr, output int aw_c, output int ar_c);
    bit a, r, w;
    aw_c = -1; ar_c = -1;
    bus.awaddr = waddr; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.wdata = 32'hABCD_0001; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
    bus.araddr = 32'h2000_0000; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      a = bus.awready; r = bus.arready; w = bus.wready;
      @(posedge clk); #1;
      if (a) begin aw_c = cyc; bus.awvalid = 1'b0; end
      if (r) begin ar_c = cyc; bus.arvalid = 1'b0; end
      if (w) begin bus.wvalid = 1'b0; bus.wlast = 1'b0; end
    end
    bus_idle();
  endtask

  vec_t vecs [12];
  logic [1:0] resp;
  int aw_c, ar_c, w0;
  bit seen;

  initial begin
    vecs[0]  = '{1'b1, 32'h2000_0010, 32'h00AB_0000, 4'b0100, 32'h0};
    vecs[1]  = '{1'b0, 32'h2000_0010, 32'h0,         4'h0,    32'hDEAB_BEEF};
    vecs[2]  = '{1'b1, 32'h2000_0020, 32'h1122_3344, 4'hF,    32'h0};
    vecs[3]  = '{1'b1, 32'h2000_0020, 32'h0000_AA00, 4'b0010, 32'h0};
    vecs[4]  = '{1'b1, 32'h2000_0020, 32'h0000_00FF, 4'b0001, 32'h0};
    vecs[5]  = '{1'b0, 32'h2000_0020, 32'h0,         4'h0,    32'h1122_AAFF};
    vecs[6]  = '{1'b1, 32'h2001_0020, 32'hCAFE_F00D, 4'hF,    32'h0};
    vecs[7]  = '{1'b0, 32'h2000_0023, 32'h0,         4'h0,    32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h2000_0020, 32'hFFFF_FFFF, 4'h0,    32'h0};
    vecs[9]  = '{1'b0, 32'h2000_0020, 32'h0,         4'h0,    32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'h2000_FFFC, 32'h0BAD_C0DE, 4'hF,    32'h0};
    vecs[11] = '{1'b0, 32'h2000_FFFC, 32'h0,         4'h0,    32'h0BAD_C0DE};

    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {22'h0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rlast,
           bus.bresp, bus.rresp},
          32'h0);
    check("reset_mem", {27'h0, mem_cs, mem_we}, 32'h0);
    rst = 1'b0;

    // W beats offered before AW must wait
    bus.wvalid = 1'b1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (bus.wready || mem_cs) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("early_wvalid_blocked", {31'h0, seen}, 32'h0);

    // single write, cycle-accurate
    bus.awaddr = 32'h2000_0010; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    #1; check("wr_awready_N", {31'h0, bus.awready}, 32'h1);
    @(posedge clk); #1; bus.awvalid = 1'b0;
    #1;
    check("wr_wready_N1", {31'h0, bus.wready}, 32'h1);
    check("wr_mem_N1", {13'h0, mem_cs, mem_we, mem_addr}, {13'h0, 1'b1, 4'hF, 14'd4});
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    #1;
    check("wr_bvalid_N2", {29'h0, bus.bvalid, bus.bresp}, {29'h0, 1'b1, 2'b00});
    bus.bready = 1'b1;
    @(posedge clk); #1; bus.bready = 1'b0;
    #1; check("wr_bvalid_drop", {31'h0, bus.bvalid}, 32'h0);
    @(posedge clk); #1;

    // single read, cycle-accurate
    bus.araddr = 32'h2000_0010; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    #1; check("rd_arready_N", {31'h0, bus.arready}, 32'h1);
    @(posedge clk); #1; bus.arvalid = 1'b0;
    #1;
    check("rd_mem_N1", {12'h0, bus.rvalid, mem_cs, mem_we, mem_addr}, {12'h0, 1'b0, 1'b1, 4'h0, 14'd4});
    @(posedge clk); #1;
    #1;
    check("rd_rvalid_N2", {28'h0, bus.rvalid, bus.rlast, bus.rresp}, {28'h0, 1'b1, 1'b1, 2'b00});
    check("rd_rdata", bus.rdata, 32'hDEAD_BEEF);
    bus.rready = 1'b1;
    @(posedge clk); #1; bus.rready = 1'b0;
    #1; check("rd_rvalid_drop", {31'h0, bus.rvalid}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, 8'd0, 2'b01, vecs[i].data, vecs[i].strb, 0, resp);
        check($sformatf("vec%0d_bresp", i), {30'h0, resp}, vecs[i].exp);
      end else begin
        do_read(vecs[i].addr, 8'd0, 2'b01, 1'b0);
        check($sformatf("vec%0d_rdata", i), rd_buf[0], vecs[i].exp);
      end
    end

    // INCR burst write then stalled INCR burst read
    do_write(32'h2000_0000, 8'd3, 2'b01, 32'hA000_0000, 4'hF, 3, resp);
    check("incr_wr_bresp", {30'h0, resp}, 32'h0);
    do_read(32'h2000_0000, 8'd3, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("incr_rd%0d", i), rd_buf[i], 32'hA000_0000 + 32'(i));
    check("incr_rlast", rd_last_err, 32'd0);
    check("incr_stable", rd_unstable, 32'd0);
    check("incr_stalled", {31'h0, rd_stalls > 0}, 32'h1);
    check("incr_rresp", rd_resp_err, 32'd0);

    // FIXED bursts stay on one word
    do_write(32'h2000_0040, 8'd2, 2'b00, 32'hF000_0000, 4'hF, 2, resp);
    check("fixed_wr_bresp", {30'h0, resp}, 32'h0);
    do_read(32'h2000_0040, 8'd1, 2'b00, 1'b0);
    check("fixed_rd0", rd_buf[0], 32'hF000_0002);
    check("fixed_rd1", rd_buf[1], 32'hF000_0002);

    // WRAP treated as INCR, wrapping past the top of the SRAM
    do_write(32'h2000_FFFC, 8'd1, 2'b10, 32'h5555_0000, 4'hF, 1, resp);
    do_read(32'h2000_FFFC, 8'd1, 2'b01, 1'b0);
    check("wrap_rd_top", rd_buf[0], 32'h5555_0000);
    check("wrap_rd_zero", rd_buf[1], 32'h5555_0001);

    // 256-beat burst
    do_write(32'h2000_1000, 8'd255, 2'b01, 32'h3000_0000, 4'hF, 255, resp);
    check("len256_bresp", {30'h0, resp}, 32'h0);
    do_read(32'h2000_13FC, 8'd0, 2'b01, 1'b0);
    check("len256_last_word", rd_buf[0], 32'h3000_00FF);

    // early wlast and missing wlast
    w0 = n_wr;
    do_write(32'h2000_0080, 8'd3, 2'b01, 32'h7777_0000, 4'hF, 1, resp);
    check("early_wlast_writes", n_wr - w0, 32'd2);
    check("early_wlast_bresp", {30'h0, resp}, 32'h2);
    do_write(32'h2000_0090, 8'd0, 2'b01, 32'h1234_5678, 4'hF, 0, resp);
    check("after_err_okay", {30'h0, resp}, 32'h0);
    do_read(32'h2000_0084, 8'd0, 2'b01, 1'b0);
    check("early_wlast_data", rd_buf[0], 32'h7777_0001);
    do_write(32'h2000_00A0, 8'd0, 2'b01, 32'h0, 4'hF, -1, resp);
    check("missing_wlast_bresp", {30'h0, resp}, 32'h2);

    // arbitration: write first after reset, read first after a write
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    arb(32'h2000_0100, aw_c, ar_c);
    check("arb1_aw_first", aw_c, 32'd0);
    check("arb1_ar_later", {31'h0, ar_c > aw_c}, 32'h1);
    do_write(32'h2000_0104, 8'd0, 2'b01, 32'h0, 4'hF, 0, resp);
    arb(32'h2000_0108, aw_c, ar_c);
    check("arb2_ar_first", ar_c, 32'd0);
    check("arb2_aw_later", {31'h0, aw_c > ar_c}, 32'h1);

    // reset in the middle of a read burst
    bus.araddr = 32'h2000_0000; bus.arlen = 8'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    wait_ready(3, seen, resp);
    bus.arvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; if (bus.rvalid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rst_reached_rdata", {31'h0, seen}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rvalid_low", {30'h0, bus.rvalid, mem_cs}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_idle_quiet", {29'h0, bus.rvalid, bus.bvalid, mem_cs}, 32'h0);
    do_read(32'h2000_0000, 8'd1, 2'b01, 1'b0);
    check("post_rst_rd0", rd_buf[0], 32'h5555_0001);
    check("post_rst_rd1", rd_buf[1], 32'hA000_0001);
    check("post_rst_rlast", rd_last_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
